// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Multi-cycle sequencer for the RV32I core. Each instruction walks through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) and back to FETCH.
//   Drives the IR/PC/regfile write strobes and the imem/dmem request
//   handshakes, counts retired instructions and aborts to HALT when a memory
//   ack does not arrive within TIMEOUT_CYCLES request cycles.
//
// Parameters
//   TIMEOUT_CYCLES  max request cycles without ack before err_timeout (1..255)
//   RETIRE_W        width of the retired-instruction counter
//
// Configuration macro
//   ILLEGAL_TRAP_EN  defined: undecoded opcode in EXECUTE -> TRAP (sticky).
//                    undefined: undecoded opcode retires as a NOP.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode, func3        decoder fields (stable DECODE..WRITEBACK)
//   branch_taken         ALU compare result, sampled in EXECUTE
//   imem_ack, dmem_ack   memory handshakes
//   imem_req, dmem_req   level requests, held until ack
//   dmem_we              1=store, 0=load, valid with dmem_req
//   ir_we, reg_we, pc_we single-cycle write strobes
//   pc_sel               0=PC+4, 1=branch/JAL target, 2=JALR target
//   state                current state encoding (debug)
//   retired              completed-instruction count (wraps)
//   err_timeout          sticky memory-timeout flag
//   trap                 sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic                branch_taken,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                reg_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                err_timeout,
  output logic                trap
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Last wait-counter value before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_wait;
  logic [7:0]            w_wait_nxt;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  r_err;
  logic                  w_retire;
  logic                  w_set_err;
  logic                  w_legal_wb;
  logic                  w_is_store;

  // func3 only passes through the datapath; the sequencer does not need it.
  logic                  w_unused_func3;
  assign w_unused_func3 = ^func3;

  assign w_is_store = (opcode == OP_STORE);

  // Opcodes that legitimately write rd in WRITEBACK.
  assign w_legal_wb = (opcode == OP_R)     || (opcode == OP_I)     ||
                      (opcode == OP_LUI)   || (opcode == OP_AUIPC) ||
                      (opcode == OP_JAL)   || (opcode == OP_JALR)  ||
                      (opcode == OP_LOAD);

`ifdef ILLEGAL_TRAP_EN
  logic w_legal;
  logic w_set_trap;
  logic r_trap;
  assign w_legal = w_legal_wb || w_is_store || (opcode == OP_BRANCH);
`endif

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_retire   = 1'b0;
    w_set_err  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_set_trap = 1'b0;
`endif
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;

    unique case (r_state)
      S_FETCH: begin
        // The state register already sits in FETCH during reset; gating the
        // request with rst_n keeps it low until reset is released.
        imem_req = rst_n;
        if (imem_ack && rst_n) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_DECODE: w_next = S_EXECUTE;

      S_EXECUTE: begin
        if ((opcode == OP_LOAD) || w_is_store) begin
          w_next     = S_MEM;
          w_wait_nxt = '0;
        end else if (opcode == OP_BRANCH) begin
          pc_we      = 1'b1;
          pc_sel     = branch_taken ? 2'd1 : 2'd0;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
          w_wait_nxt = '0;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          if (!w_legal) begin
            w_set_trap = 1'b1;
            w_next     = S_TRAP;
          end else begin
            w_next = S_WRITEBACK;
          end
`else
          w_next = S_WRITEBACK;
`endif
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) begin
          if (w_is_store) begin
            pc_we      = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
            w_wait_nxt = '0;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_WRITEBACK: begin
        // Undecoded opcodes reach here only as NOPs: no rd write.
        reg_we     = w_legal_wb;
        pc_we      = 1'b1;
        pc_sel     = (opcode == OP_JAL)  ? 2'd1 :
                     (opcode == OP_JALR) ? 2'd2 : 2'd0;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
        w_wait_nxt = '0;
      end

      S_TRAP, S_HALT: w_next = r_state;

      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
      if (w_set_err) r_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_trap <= 1'b0;
    else if (w_set_trap) r_trap <= 1'b1;
  end
  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

  assign state       = r_state;
  assign retired     = r_retired;
  assign err_timeout = r_err;

endmodule
